rf_wb_ctrl: RTL and testbench
=============================

Name: rf_wb_ctrl

Overview:
- Writeback-side controller that owns the register-file write port (rd address, write enable, write data) in the pipelined RV32I core.
- Merges two result sources onto that single write port:
  - the in-order pipeline WB stage, which cannot be back-pressured;
  - long-latency results (LSU miss / MDU), delivered with valid/ready into a small FIFO.
- Keeps a per-register busy scoreboard so decode can stall RAW/WAW hazards on outstanding long-latency destinations.

Parameters:
- XLEN, 32, data width.
- FIFO_DEPTH, 4, long-latency result queue depth; must be a power of 2 and at least 2.
- STARVE_LIMIT, 8, blocked-head cycle count that triggers the starvation guard (used only with the optional feature).

Ports:
- i_clk  in  1  clock
- i_reset  in  1  asynchronous, active-low reset
- i_wb_valid  in  1  pipeline WB result valid
- i_wb_rd  in  5  pipeline WB destination
- i_wb_data  in  XLEN  pipeline WB data
- i_lu_issue  in  1  long-latency op issued this cycle (from decode)
- i_lu_issue_rd  in  5  destination of issued op
- i_lu_valid  in  1  long-latency result valid
- i_lu_rd  in  5  long-latency result destination
- i_lu_data  in  XLEN  long-latency result data
- o_lu_ready  out  1  FIFO can accept a result (not full)
- o_rd_wren  out  1  to regfile write enable
- o_rd_addr  out  5  to regfile write address
- o_rd_data  out  XLEN  to regfile write data
- o_busy  out  32  scoreboard; bit n is set while xn has an outstanding long-latency write
- o_pipe_stall  out  1  freeze WB stage (optional feature only; otherwise tied 0)
- o_err  out  1  sticky protocol error

Behaviour:
- Reset (i_reset=0, asynchronous):
  - FIFO pointers, count, o_busy, o_err and the starve counter clear.
  - o_rd_wren=0, o_rd_addr=0, o_rd_data=0, o_lu_ready=0 while reset is asserted.
  - o_lu_ready=1 from the first clock after reset release.
  - A reset mid-operation discards queued entries.
- Write port arbitration is combinational, with zero latency:
  - Priority 1, pipeline slot: taken when i_wb_valid=1 and i_wb_rd!=0. Outputs o_rd_wren=1, o_rd_addr=i_wb_rd, o_rd_data=i_wb_data.
  - Priority 2, FIFO head: taken when the pipeline slot is not taken and the FIFO is not empty. Outputs the head entry and pops it at the clock edge.
  - Otherwise o_rd_wren=0, o_rd_addr=0, o_rd_data=0.
  - i_wb_valid with i_wb_rd=0 counts as an idle slot.
- FIFO:
  - Push on i_lu_valid & o_lu_ready. o_lu_ready = !full.
  - Simultaneous push and pop when full is not allowed: o_lu_ready is computed from the registered count only, with no same-cycle pop credit.
  - Push and pop in the same cycle when not full leaves the count unchanged.
  - Pointers are log2(FIFO_DEPTH) bits and wrap naturally.
  - An entry with rd=0 is still pushed and popped, but drives o_rd_wren=0 when popped.
- Scoreboard:
  - Set: i_lu_issue with i_lu_issue_rd!=0 sets bit rd at the clock edge.
  - Clear: a FIFO pop to rd clears bit rd.
  - If set and clear hit the same rd in the same cycle, set wins.
  - Issue to an rd that is already busy sets o_err; the bit stays set.
- Error conditions that set o_err:
  - issue to an already-busy rd;
  - i_lu_valid for an rd whose busy bit is 0;
  - i_wb_valid to an rd that is busy (WAW against decode).
- WAW ordering: the pipeline write happens first and the later FIFO pop overwrites it.
- o_err clears only on reset.

Optional Feature:
- Macro: RF_WB_STARVE_GUARD_EN.
- With the macro defined:
  - A counter increments each cycle the FIFO is non-empty and the head is blocked by a pipeline write.
  - The counter resets on every pop.
  - When the counter reaches STARVE_LIMIT, o_pipe_stall is asserted combinationally for exactly one cycle.
  - In that cycle the FIFO head takes the port, i_wb_* is ignored, and the pipeline holds WB for the next cycle.
- Without the macro: o_pipe_stall is tied 0 and the counter is not built.

Decomposition:
- Shared package rf_wb_pkg:
  - constants REG_ADDR_W=5 and NUM_REGS=32;
  - typedef lu_entry_t as a packed struct {rd, data};
  - enum wb_src_e {SRC_NONE, SRC_PIPE, SRC_LU}.
- One natural sub-module: rf_wb_fifo, a parameterised sync FIFO of lu_entry_t with push/pop/full/empty/count.

Test Plan:
- Pipeline only: i_wb_valid=1, rd=5, data=0xDEADBEEF, FIFO empty -> same-cycle o_rd_wren=1, o_rd_addr=5, o_rd_data=0xDEADBEEF; with rd=0 -> o_rd_wren=0.
- Conflict: issue rd=7; LU result rd=7, data=0x11 pushed while pipeline writes rd=3 for 2 cycles -> rd=3 written on both cycles, then rd=7/0x11 on the first idle cycle, and o_busy[7] falls on that edge.
- Full FIFO: issue 4 ops to rd=1..4 and push 4 results with the pipeline saturated -> o_lu_ready=0 after the 4th push; release the pipeline -> writes to rd 1,2,3,4 in order, and o_lu_ready=1 after the first pop.
- Errors: issue rd=9 twice -> o_err=1 sticky; after reset, LU result to non-busy rd=12 -> o_err=1.
- Reset mid-drain: 3 entries queued, assert i_reset -> o_rd_wren=0 immediately, o_busy=0, and no stale write after release.
- With RF_WB_STARVE_GUARD_EN: FIFO non-empty and pipeline writing continuously -> o_pipe_stall=1 for one cycle on the 8th blocked cycle, and the head is written in that cycle.

Source files
------------

// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback controller.
package rf_wb_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int NUM_REGS   = 32;
  localparam int DATA_W     = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] rd;
    logic [DATA_W-1:0]     data;
  } lu_entry_t;

  typedef enum logic [1:0] {
    SRC_NONE,
    SRC_PIPE,
    SRC_LU
  } wb_src_e;

endpackage

// File: rtl/rf_wb_fifo.sv
// Small synchronous FIFO of long-latency results; the head is readable
// combinationally so the write port can take it in the same cycle.
module rf_wb_fifo
  import rf_wb_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic      i_clk,
  input  logic      i_reset,
  input  logic      push,
  input  lu_entry_t push_entry,
  input  logic      pop,
  output lu_entry_t head,
  output logic      full,
  output logic      empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  lu_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic [CNT_W-1:0] count_next;

  always_comb begin
    count_next = count_reg;
    case ({push, pop})
      2'b10:   count_next = count_reg + CNT_W'(1);
      2'b01:   count_next = count_reg - CNT_W'(1);
      default: count_next = count_reg;
    endcase
  end

  // Pointers are exactly log2(DEPTH) wide, so they wrap without compare logic.
  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      count_reg <= count_next;
    end
  end

  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr_reg] <= push_entry;
  end

  assign head  = mem[rd_ptr_reg];
  assign full  = (count_reg == CNT_W'(DEPTH));
  assign empty = (count_reg == '0);

endmodule

// File: rtl/rf_wb_ctrl.sv
// Register-file write port owner: merges pipeline WB and queued long-latency
// results, and tracks busy destinations. Optional macro: RF_WB_STARVE_GUARD_EN.
module rf_wb_ctrl
  import rf_wb_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter int FIFO_DEPTH   = 4,
  parameter int STARVE_LIMIT = 8
) (
  input  logic            i_clk,
  input  logic            i_reset,
  input  logic            i_wb_valid,
  input  logic [4:0]      i_wb_rd,
  input  logic [XLEN-1:0] i_wb_data,
  input  logic            i_lu_issue,
  input  logic [4:0]      i_lu_issue_rd,
  input  logic            i_lu_valid,
  input  logic [4:0]      i_lu_rd,
  input  logic [XLEN-1:0] i_lu_data,
  output logic            o_lu_ready,
  output logic            o_rd_wren,
  output logic [4:0]      o_rd_addr,
  output logic [XLEN-1:0] o_rd_data,
  output logic [31:0]     o_busy,
  output logic            o_pipe_stall,
  output logic            o_err
);

  if (XLEN != DATA_W) begin : g_bad_xlen
    $error("rf_wb_ctrl: XLEN must match rf_wb_pkg::DATA_W");
  end
  if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
    $error("rf_wb_ctrl: FIFO_DEPTH must be a power of 2 and >= 2");
  end
  if (STARVE_LIMIT < 1) begin : g_bad_limit
    $error("rf_wb_ctrl: STARVE_LIMIT must be >= 1");
  end

  wb_src_e               src;
  lu_entry_t             fifo_head;
  logic                  fifo_full;
  logic                  fifo_empty;
  logic                  fifo_push;
  logic                  fifo_pop;
  logic                  pipe_req;
  logic                  ready_en_reg;
  logic                  err_reg;
  logic                  err_next;
  logic [NUM_REGS-1:0]   busy_reg;
  logic [NUM_REGS-1:0]   busy_next;

  // Ready stays low until the first edge after reset release.
  assign o_lu_ready = ready_en_reg && !fifo_full;
  assign fifo_push  = i_lu_valid && o_lu_ready;
  assign fifo_pop   = (src == SRC_LU);
  assign pipe_req   = i_reset && i_wb_valid && (i_wb_rd != '0);

  rf_wb_fifo #(
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .i_clk     (i_clk),
    .i_reset   (i_reset),
    .push      (fifo_push),
    .push_entry('{rd: i_lu_rd, data: i_lu_data}),
    .pop       (fifo_pop),
    .head      (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

`ifdef RF_WB_STARVE_GUARD_EN
  localparam int SC_W = $clog2(STARVE_LIMIT + 1);
  logic [SC_W-1:0] starve_cnt_reg;

  // Fires on the STARVE_LIMIT-th consecutive blocked cycle and forces a pop.
  assign o_pipe_stall = !fifo_empty && pipe_req &&
                        (starve_cnt_reg == SC_W'(STARVE_LIMIT - 1));

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      starve_cnt_reg <= '0;
    end else if (fifo_pop) begin
      starve_cnt_reg <= '0;
    end else if (pipe_req && !fifo_empty) begin
      starve_cnt_reg <= starve_cnt_reg + SC_W'(1);
    end
  end
`else
  assign o_pipe_stall = 1'b0;
`endif

  always_comb begin
    src = SRC_NONE;
    if (pipe_req && !o_pipe_stall) begin
      src = SRC_PIPE;
    end else if (i_reset && !fifo_empty) begin
      src = SRC_LU;
    end
  end

  always_comb begin
    o_rd_wren = 1'b0;
    o_rd_addr = '0;
    o_rd_data = '0;
    case (src)
      SRC_PIPE: begin
        o_rd_wren = 1'b1;
        o_rd_addr = i_wb_rd;
        o_rd_data = i_wb_data;
      end
      SRC_LU: begin
        o_rd_wren = (fifo_head.rd != '0);
        o_rd_addr = fifo_head.rd;
        o_rd_data = fifo_head.data;
      end
      default: ;
    endcase
  end

  // Per-register scoreboard; a same-cycle issue beats the retiring pop.
  genvar gi;
  for (gi = 0; gi < NUM_REGS; gi++) begin : g_busy
    logic set_bit;
    logic clr_bit;
    assign set_bit = i_lu_issue && (i_lu_issue_rd == REG_ADDR_W'(gi)) && (gi != 0);
    assign clr_bit = fifo_pop && (fifo_head.rd == REG_ADDR_W'(gi));
    assign busy_next[gi] = set_bit || (busy_reg[gi] && !clr_bit);
  end

  always_comb begin
    err_next = err_reg;
    if (i_lu_issue && (i_lu_issue_rd != '0) && busy_reg[i_lu_issue_rd]) err_next = 1'b1;
    if (i_lu_valid && !busy_reg[i_lu_rd])                                err_next = 1'b1;
    if (pipe_req && !o_pipe_stall && busy_reg[i_wb_rd])                  err_next = 1'b1;
  end

  always_ff @(posedge i_clk or negedge i_reset) begin
    if (!i_reset) begin
      ready_en_reg <= 1'b0;
      err_reg      <= 1'b0;
      busy_reg     <= '0;
    end else begin
      ready_en_reg <= 1'b1;
      err_reg      <= err_next;
      busy_reg     <= busy_next;
    end
  end

  assign o_busy = busy_reg;
  assign o_err  = err_reg;

endmodule

// File: tb/tb_rf_wb_ctrl.sv
// Scoreboard bench for rf_wb_ctrl: directed scenarios plus legal random traffic
// checked cycle by cycle against a queue-based reference model.
module tb_rf_wb_ctrl;

  localparam int DEPTH        = 4;
  localparam int STARVE_LIMIT = 8;

  logic        i_clk;
  logic        i_reset;
  logic        i_wb_valid;
  logic [4:0]  i_wb_rd;
  logic [31:0] i_wb_data;
  logic        i_lu_issue;
  logic [4:0]  i_lu_issue_rd;
  logic        i_lu_valid;
  logic [4:0]  i_lu_rd;
  logic [31:0] i_lu_data;
  logic        o_lu_ready;
  logic        o_rd_wren;
  logic [4:0]  o_rd_addr;
  logic [31:0] o_rd_data;
  logic [31:0] o_busy;
  logic        o_pipe_stall;
  logic        o_err;

  rf_wb_ctrl #(
    .XLEN(32), .FIFO_DEPTH(DEPTH), .STARVE_LIMIT(STARVE_LIMIT)
  ) dut (
    .i_clk        (i_clk),
    .i_reset      (i_reset),
    .i_wb_valid   (i_wb_valid),
    .i_wb_rd      (i_wb_rd),
    .i_wb_data    (i_wb_data),
    .i_lu_issue   (i_lu_issue),
    .i_lu_issue_rd(i_lu_issue_rd),
    .i_lu_valid   (i_lu_valid),
    .i_lu_rd      (i_lu_rd),
    .i_lu_data    (i_lu_data),
    .o_lu_ready   (o_lu_ready),
    .o_rd_wren    (o_rd_wren),
    .o_rd_addr    (o_rd_addr),
    .o_rd_data    (o_rd_data),
    .o_busy       (o_busy),
    .o_pipe_stall (o_pipe_stall),
    .o_err        (o_err)
  );

  initial i_clk = 1'b0;
  always #5 i_clk = ~i_clk;

  typedef struct {
    bit          wren;
    bit          chk_ad;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [31:0] busy;
    bit          ready;
    bit          err;
    bit          stall;
    int          cyc;
  } exp_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } ent_t;

  exp_t        exp_q[$];
  ent_t        mq[$];
  logic [31:0] busy_m;
  logic [31:0] pending;
  bit          err_m;
  bit          started;
  int          cnt_m;
  int          cyc;
  int          n_cmp;
  int          n_bad;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req, input int c);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s cyc=%0d got=%h expected=%h", nm, c, act, req);
    end
  endtask

  // Reference model: plain queue + bit vectors evaluated from the rules.
  task automatic drive(input logic wv, input logic [4:0] wrd, input logic [31:0] wd,
                       input logic iss, input logic [4:0] ird,
                       input logic lv, input logic [4:0] lrd, input logic [31:0] ld,
                       input logic rstn);
    exp_t e;
    ent_t h;
    bit   pipe_req;
    bit   pop;
    bit   had_data;
    i_reset = rstn; i_wb_valid = wv; i_wb_rd = wrd; i_wb_data = wd;
    i_lu_issue = iss; i_lu_issue_rd = ird;
    i_lu_valid = lv; i_lu_rd = lrd; i_lu_data = ld;
    cyc++;
    e.cyc = cyc; e.wren = 0; e.chk_ad = 1; e.addr = 0; e.data = 0;
    e.stall = 0; e.ready = 0; e.busy = 0; e.err = 0;
    if (!rstn) begin
      mq.delete();
      busy_m = 0; pending = 0; err_m = 0; cnt_m = 0; started = 0;
    end else begin
      e.ready  = started && (mq.size() < DEPTH);
      pipe_req = wv && (wrd != 0);
      had_data = (mq.size() > 0);
`ifdef RF_WB_STARVE_GUARD_EN
      e.stall = had_data && pipe_req && (cnt_m == STARVE_LIMIT - 1);
`endif
      pop = 0;
      if (pipe_req && !e.stall) begin
        e.wren = 1; e.addr = wrd; e.data = wd;
      end else if (had_data) begin
        pop = 1; h = mq[0];
        e.wren = (h.rd != 0); e.addr = h.rd; e.data = h.data; e.chk_ad = (h.rd != 0);
      end
      e.busy = busy_m;
      e.err  = err_m;
      if (iss && busy_m[ird]) err_m = 1;
      if (lv && !busy_m[lrd]) err_m = 1;
      if (pipe_req && !e.stall && busy_m[wrd]) err_m = 1;
      if (pop) begin
        h = mq.pop_front();
        if (h.rd != 0) busy_m[h.rd] = 0;
      end
      if (iss && ird != 0) begin busy_m[ird] = 1; pending[ird] = 1; end
      if (lv && e.ready) begin mq.push_back('{lrd, ld}); pending[lrd] = 0; end
      if (pop) cnt_m = 0;
      else if (had_data && pipe_req) cnt_m++;
      started = 1;
    end
    exp_q.push_back(e);
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle(input logic rstn);
    drive(0, 0, 0, 0, 0, 0, 0, 0, rstn);
  endtask

  task automatic rand_cycle();
    logic wv, iss, lv;
    logic [4:0] wrd, ird, lrd, c;
    int k;
    wv = ($urandom_range(0, 99) < 60); wrd = 0;
    if (wv) begin c = 5'($urandom); if (!busy_m[c]) wrd = c; end
    iss = 0; ird = 0;
    if ($urandom_range(0, 99) < 25) begin
      c = 5'($urandom);
      if (c != 0 && !busy_m[c]) begin iss = 1; ird = c; end
    end
    lv = 0; lrd = 0;
    if ($urandom_range(0, 99) < 45 && pending != 0) begin
      k = $urandom_range(0, 31);
      for (int j = 0; j < 32; j++) begin
        c = 5'((k + j) % 32);
        if (!lv && pending[c]) begin lv = 1; lrd = c; end
      end
    end
    drive(wv, wrd, $urandom, iss, ird, lv, lrd, $urandom, $urandom_range(0, 199) != 0);
    tick();
  endtask

  // Monitor: one expected entry per cycle, compared mid-cycle.
  initial begin
    exp_t e;
    forever begin
      @(negedge i_clk);
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("wren", 32'(o_rd_wren), 32'(e.wren), e.cyc);
        if (e.chk_ad) begin
          chk("addr", 32'(o_rd_addr), 32'(e.addr), e.cyc);
          chk("data", o_rd_data, e.data, e.cyc);
        end
        chk("busy", o_busy, e.busy, e.cyc);
        chk("ready", 32'(o_lu_ready), 32'(e.ready), e.cyc);
        chk("err", 32'(o_err), 32'(e.err), e.cyc);
        chk("stall", 32'(o_pipe_stall), 32'(e.stall), e.cyc);
        if (o_rd_wren)
          $display("cyc %0d write x%0d <= %08h", e.cyc, o_rd_addr, o_rd_data);
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog cyc=%0d got=timeout expected=finish", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    busy_m = 0; pending = 0; err_m = 0; started = 0; cnt_m = 0;
    i_reset = 0; i_wb_valid = 0; i_wb_rd = 0; i_wb_data = 0;
    i_lu_issue = 0; i_lu_issue_rd = 0; i_lu_valid = 0; i_lu_rd = 0; i_lu_data = 0;
    @(posedge i_clk); #1;
    idle(0); #2 chk("reset_wren", 32'(o_rd_wren), 0, cyc); chk("reset_ready", 32'(o_lu_ready), 0, cyc); tick();
    idle(0); tick();

    // Pipeline only
    drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 0, 0, 1); #2
    chk("pipe_wren", 32'(o_rd_wren), 1, cyc);
    chk("pipe_addr", 32'(o_rd_addr), 5, cyc);
    chk("pipe_data", o_rd_data, 32'hDEADBEEF, cyc);
    chk("ready_at_release", 32'(o_lu_ready), 0, cyc);
    tick();
    drive(1, 0, 32'h12345678, 0, 0, 0, 0, 0, 1); #2
    chk("pipe_rd0_wren", 32'(o_rd_wren), 0, cyc);
    chk("ready_after_release", 32'(o_lu_ready), 1, cyc);
    tick();

    // Conflict: LU result waits behind two pipeline writes
    drive(0, 0, 0, 1, 7, 0, 0, 0, 1); tick();
    drive(1, 3, 32'hA, 0, 0, 1, 7, 32'h11, 1); #2 chk("conf_addr0", 32'(o_rd_addr), 3, cyc); tick();
    drive(1, 3, 32'hB, 0, 0, 0, 0, 0, 1); #2 chk("conf_addr1", 32'(o_rd_addr), 3, cyc); tick();
    idle(1); #2
    chk("conf_lu_addr", 32'(o_rd_addr), 7, cyc);
    chk("conf_lu_data", o_rd_data, 32'h11, cyc);
    chk("conf_busy_hi", 32'(o_busy[7]), 1, cyc);
    tick();
    idle(1); #2 chk("conf_busy_lo", 32'(o_busy[7]), 0, cyc); tick();

    // Fill the FIFO while the pipeline saturates the port
    for (int i = 1; i <= 4; i++) begin drive(1, 20, 32'(i), 1, 5'(i), 0, 0, 0, 1); tick(); end
    for (int i = 1; i <= 4; i++) begin drive(1, 20, 32'(100 + i), 0, 0, 1, 5'(i), 32'hF0 + 32'(i), 1); tick(); end
    idle(1); #2
    chk("full_ready", 32'(o_lu_ready), 0, cyc);
    chk("drain_addr1", 32'(o_rd_addr), 1, cyc);
    tick();
    for (int i = 2; i <= 4; i++) begin
      idle(1); #2
      chk("drain_ready", 32'(o_lu_ready), 1, cyc);
      chk("drain_addr", 32'(o_rd_addr), 32'(i), cyc);
      tick();
    end
    idle(1); tick();

    // Errors
    drive(0, 0, 0, 1, 9, 0, 0, 0, 1); tick();
    drive(0, 0, 0, 1, 9, 0, 0, 0, 1); tick();
    idle(1); #2 chk("err_double_issue", 32'(o_err), 1, cyc); tick();
    idle(1); #2 chk("err_sticky", 32'(o_err), 1, cyc); tick();
    idle(0); #2 chk("err_reset", 32'(o_err), 0, cyc); tick();
    idle(1); tick();
    drive(0, 0, 0, 0, 0, 1, 12, 32'h77, 1); tick();
    idle(1); #2 chk("err_unbusy_lu", 32'(o_err), 1, cyc); tick();
    idle(0); tick();
    idle(1); tick();

    // Reset while entries are queued
    drive(1, 20, 1, 1, 10, 0, 0, 0, 1); tick();
    drive(1, 20, 2, 1, 11, 0, 0, 0, 1); tick();
    drive(1, 20, 3, 1, 13, 0, 0, 0, 1); tick();
    drive(1, 20, 4, 0, 0, 1, 10, 32'hA0, 1); tick();
    drive(1, 20, 5, 0, 0, 1, 11, 32'hB0, 1); tick();
    drive(1, 20, 6, 0, 0, 1, 13, 32'hD0, 1); tick();
    drive(1, 20, 7, 0, 0, 0, 0, 0, 0); #2
    chk("rst_wren", 32'(o_rd_wren), 0, cyc);
    chk("rst_busy", o_busy, 0, cyc);
    tick();
    for (int i = 0; i < 4; i++) begin idle(1); #2 chk("rst_no_stale", 32'(o_rd_wren), 0, cyc); tick(); end

`ifdef RF_WB_STARVE_GUARD_EN
    drive(0, 0, 0, 1, 15, 0, 0, 0, 1); tick();
    drive(1, 20, 0, 0, 0, 1, 15, 32'h55, 1); tick();
    for (int k = 1; k <= 7; k++) begin
      drive(1, 20, 32'(k), 0, 0, 0, 0, 0, 1); #2
      chk("starve_wait", 32'(o_pipe_stall), 0, cyc);
      tick();
    end
    drive(1, 20, 32'h8, 0, 0, 0, 0, 0, 1); #2
    chk("starve_stall", 32'(o_pipe_stall), 1, cyc);
    chk("starve_addr", 32'(o_rd_addr), 15, cyc);
    chk("starve_data", o_rd_data, 32'h55, cyc);
    tick();
    drive(1, 20, 32'h9, 0, 0, 0, 0, 0, 1); #2
    chk("starve_release", 32'(o_pipe_stall), 0, cyc);
    tick();
`endif

    // Legal random traffic
    idle(0); tick();
    for (int n = 0; n < 2000; n++) rand_cycle();
    idle(1); tick();
    @(negedge i_clk); #1;
    chk("scoreboard_drained", 32'(exp_q.size()), 0, cyc);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
